// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer between the UART
// receiver (byte + ready level) and the GPIO polling path. Each rising
// edge of rx_valid captures one byte; GPIO pops the head after reading it.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              pop,
    input  logic              clr_overflow,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rx_valid_q;
    logic              push_req;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    // Flags come from the registered count only, so nothing here depends
    // combinationally on pop or rx_valid.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    // One push per rising edge of the ready level. A pop while full frees a
    // slot in the same cycle, so the push is still accepted then.
    assign push_req = rx_valid & ~rx_valid_q;
    assign do_pop   = pop & ~empty;
    assign do_push  = push_req & (~full | do_pop);
    assign drop     = push_req & full & ~do_pop;

    // Edge-detect register; resets high so a level already present at
    // reset release is not mistaken for a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_valid_q <= 1'b1;
        else        rx_valid_q <= rx_valid;
    end

    // Storage array: written on accepted pushes, deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_byte;
    end

    // Pointers wrap naturally through ADDR_W-bit arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy is its own register so full and empty stay distinguishable
    // when the pointers are equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of expected bytes.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            pop;
    logic            clr_overflow;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb [$];
    logic       exp_ovf;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .pop(pop), .clr_overflow(clr_overflow), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one accepted or dropped byte, applied when stimulus is driven.
    task automatic model_push(input logic [7:0] b);
        if (sb.size() < DEPTH) sb.push_back(b);
        else                   exp_ovf = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        model_push(b);
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    // Compares the head against the scoreboard, then pops it.
    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (sb.size() == 0) ? 8'h00 : sb[0];
        chk(tag, {24'h0, rd_data}, {24'h0, e});
        pop = 1'b1;
        tick();
        pop = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, {27'h0, count}, sb.size());
        chk({tag, "_empty"}, {31'h0, empty}, {31'h0, sb.size() == 0});
        chk({tag, "_full"},  {31'h0, full},  {31'h0, sb.size() == DEPTH});
        chk({tag, "_ovf"},   {31'h0, overflow}, {31'h0, exp_ovf});
    endtask

    task automatic clear_ovf();
        clr_overflow = 1'b1;
        exp_ovf      = 1'b0;
        tick();
        clr_overflow = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b1; rx_byte = 8'hA5;
        pop = 1'b0; clr_overflow = 1'b0; exp_ovf = 1'b0;

        // Reset with rx_valid already high: release pushes nothing.
        #23 rst_n = 1'b1;
        repeat (5) tick();
        check_state("rst");
        chk("rst_rd", {24'h0, rd_data}, 32'h0);
        rx_valid = 1'b0;
        tick();
        chk("rst_nopush", {27'h0, count}, 32'd0);

        // Three bytes, first-word-fall-through, drain to empty.
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        check_state("abc");
        chk("abc_head", {24'h0, rd_data}, 32'h41);
        pop_check("abc_p0"); pop_check("abc_p1"); pop_check("abc_p2");
        check_state("abc_drained");
        chk("abc_rd0", {24'h0, rd_data}, 32'h0);
        pop_check("pop_empty");
        check_state("pop_empty");

        // Level held high for 10 cycles yields one entry.
        rx_byte = 8'h55; rx_valid = 1'b1; model_push(8'h55);
        repeat (10) tick();
        rx_valid = 1'b0;
        tick();
        check_state("level");
        pop_check("level_p");

        // 17 bytes into 16 entries: last one dropped, overflow set.
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check_state("ovf");
        chk("ovf_head", {24'h0, rd_data}, 32'h0);
        while (sb.size() != 0) pop_check("ovf_drain");
        check_state("ovf_drained");
        clear_ovf();
        check_state("ovf_clr");

        // Full with simultaneous push and pop: both happen, no overflow.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        check_state("full");
        rx_byte = 8'h30; rx_valid = 1'b1; pop = 1'b1;
        void'(sb.pop_front()); sb.push_back(8'h30);
        tick();
        rx_valid = 1'b0; pop = 1'b0;
        tick();
        check_state("pushpop_full");
        chk("pushpop_head", {24'h0, rd_data}, 32'h21);

        // Clear in the same cycle as a dropping push: set wins.
        rx_byte = 8'h99; rx_valid = 1'b1; clr_overflow = 1'b1;
        exp_ovf = 1'b1;
        tick();
        rx_valid = 1'b0; clr_overflow = 1'b0;
        tick();
        check_state("clr_vs_drop");
        while (sb.size() != 0) pop_check("full_drain");
        clear_ovf();

        // 40 push/pop pairs wrap the pointers more than twice.
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h80 + 8'(i));
            chk("wrap_cnt", {27'h0, count}, 32'd1);
            pop_check("wrap_data");
        end
        check_state("wrap_end");

        // Async reset mid-operation with rx_valid high.
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        check_state("pre_rst");
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_empty", {31'h0, empty}, 32'd1);
        chk("arst_count", {27'h0, count}, 32'd0);
        chk("arst_rd",    {24'h0, rd_data}, 32'h0);
        #10 rst_n = 1'b1;
        repeat (3) tick();
        check_state("arst_release");
        rx_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
